fifo_rd_port: RTL and testbench



---
 rtl/fifo_rd_pkg.sv | 12 +
 rtl/fifo_rd_skid.sv | 95 +++++++++
 rtl/fifo_rd_port.sv | 117 +++++++++++
 tb/tb_fifo_rd_port.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO read-port controller and its output buffer.
package fifo_rd_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rd_state_e;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_WIDTH = 2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry {data, ptr} output buffer with push/pop/clear; slot 0 is always the head.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PTR_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     push_data_i,
    input  logic [PTR_WIDTH-1:0] push_ptr_i,
    input  logic                 pop_i,
    input  logic                 clear_i,
    output logic [WIDTH-1:0]     head_data_o,
    output logic [PTR_WIDTH-1:0] head_ptr_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0]     head_data_q, head_data_d;
    logic [PTR_WIDTH-1:0] head_ptr_q, head_ptr_d;
    logic [WIDTH-1:0]     tail_data_q, tail_data_d;
    logic [PTR_WIDTH-1:0] tail_ptr_q, tail_ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pop_eff;
    logic                 push_eff;

    // Guard against popping an empty buffer or pushing into a full one without a pop.
    assign pop_eff  = pop_i && (cnt_q != '0);
    assign push_eff = push_i && ((cnt_q != CNT_WIDTH'(BUF_DEPTH)) || pop_eff);

    always_comb begin
        head_data_d = head_data_q;
        head_ptr_d  = head_ptr_q;
        tail_data_d = tail_data_q;
        tail_ptr_d  = tail_ptr_q;
        cnt_d       = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else begin
            case ({push_eff, pop_eff})
                2'b10: begin
                    if (cnt_q == '0) begin
                        head_data_d = push_data_i;
                        head_ptr_d  = push_ptr_i;
                    end else begin
                        tail_data_d = push_data_i;
                        tail_ptr_d  = push_ptr_i;
                    end
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                2'b01: begin
                    head_data_d = tail_data_q;
                    head_ptr_d  = tail_ptr_q;
                    cnt_d       = cnt_q - CNT_WIDTH'(1);
                end
                2'b11: begin
                    // Occupancy is unchanged; the new entry lands behind whatever remains.
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        head_data_d = push_data_i;
                        head_ptr_d  = push_ptr_i;
                    end else begin
                        head_data_d = tail_data_q;
                        head_ptr_d  = tail_ptr_q;
                        tail_data_d = push_data_i;
                        tail_ptr_d  = push_ptr_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_data_q <= '0;
            head_ptr_q  <= '0;
            tail_data_q <= '0;
            tail_ptr_q  <= '0;
            cnt_q       <= '0;
        end else begin
            head_data_q <= head_data_d;
            head_ptr_q  <= head_ptr_d;
            tail_data_q <= tail_data_d;
            tail_ptr_q  <= tail_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign head_data_o = head_data_q;
    assign head_ptr_o  = head_ptr_q;
    assign cnt_o       = cnt_q;

endmodule

// File: rtl/fifo_rd_port.sv
// Read-side controller for the Tomasulo FIFO: pops into a 2-entry buffer, flushes by pointer rewind.
// Optional delivered-entry counter (pop_cnt) is built when FIFO_RD_PORT_STATS_EN is defined.
module fifo_rd_port
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PTR_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic [PTR_WIDTH-1:0] fifo_r_ptr,
    input  logic                 fifo_r_fail,
    output logic                 fifo_r_en,
    output logic                 fifo_change_r_ptr_en,
    output logic [PTR_WIDTH-1:0] fifo_change_r_ptr_value,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [PTR_WIDTH-1:0] out_ptr,
    input  logic                 out_ready,
    input  logic                 flush,
    input  logic [PTR_WIDTH-1:0] flush_ptr,
    output logic                 err
`ifdef FIFO_RD_PORT_STATS_EN
    ,
    output logic [15:0]          pop_cnt
`endif
);

    rd_state_e            state_q, state_d;
    logic [PTR_WIDTH-1:0] flush_ptr_q, flush_ptr_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 pop_fifo;
    logic                 accept;

    // Pop gating depends only on registered occupancy, never on out_ready.
    always_comb begin
        state_d              = state_q;
        flush_ptr_d          = flush_ptr_q;
        pop_fifo             = 1'b0;
        fifo_change_r_ptr_en = 1'b0;
        case (state_q)
            RUN: begin
                pop_fifo = !reset && !fifo_empty && !flush && (cnt < CNT_WIDTH'(BUF_DEPTH));
                if (flush) begin
                    state_d     = FLUSH;
                    flush_ptr_d = flush_ptr;
                end
            end
            FLUSH: begin
                fifo_change_r_ptr_en = 1'b1;
                if (flush) begin
                    flush_ptr_d = flush_ptr;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign out_valid = (cnt != '0);
    assign accept    = out_valid && out_ready && !flush;
    assign err_d     = err_q || fifo_r_fail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            flush_ptr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_ptr_q <= flush_ptr_d;
            err_q       <= err_d;
        end
    end

    fifo_rd_skid #(
        .WIDTH     (WIDTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (pop_fifo),
        .push_data_i (fifo_dout),
        .push_ptr_i  (fifo_r_ptr),
        .pop_i       (accept),
        .clear_i     (flush),
        .head_data_o (out_data),
        .head_ptr_o  (out_ptr),
        .cnt_o       (cnt)
    );

    assign fifo_r_en               = pop_fifo;
    assign fifo_change_r_ptr_value = flush_ptr_q;
    assign err                     = err_q;

`ifdef FIFO_RD_PORT_STATS_EN
    logic [15:0] pop_cnt_q;

    // Counts delivered entries only; a handshake swallowed by a flush is not a delivery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_cnt_q <= '0;
        end else if (accept) begin
            pop_cnt_q <= pop_cnt_q + 16'd1;
        end
    end

    assign pop_cnt = pop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_port.sv
// Testbench for fifo_rd_port: the bench plays the FIFO and scores delivered entries in FIFO order.
module tb_fifo_rd_port;

    localparam int WIDTH     = 32;
    localparam int PTR_WIDTH = 6;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 fifo_empty;
    logic [WIDTH-1:0]     fifo_dout;
    logic [PTR_WIDTH-1:0] fifo_r_ptr;
    logic                 fifo_r_fail;
    logic                 fifo_r_en;
    logic                 fifo_change_r_ptr_en;
    logic [PTR_WIDTH-1:0] fifo_change_r_ptr_value;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [PTR_WIDTH-1:0] out_ptr;
    logic                 out_ready = 1'b0;
    logic                 flush = 1'b0;
    logic [PTR_WIDTH-1:0] flush_ptr = '0;
    logic                 err;
`ifdef FIFO_RD_PORT_STATS_EN
    logic [15:0]          pop_cnt;
`endif

    // FIFO model: 32 slots addressed by the low pointer bits, empty when pointers match.
    logic [WIDTH-1:0]     mem [32];
    logic [PTR_WIDTH-1:0] rptr = '0;
    logic [PTR_WIDTH-1:0] wptr = '0;
    logic                 failInject = 1'b0;

    // Reference state: next pointer owed downstream, last flush target, flush-cycle flag.
    logic [PTR_WIDTH-1:0] nextPtr = '0;
    logic [PTR_WIDTH-1:0] lastFlushPtr = '0;
    logic                 flushWindow = 1'b0;
    logic                 errExp = 1'b0;
    int                   delivered = 0;
    int                   obsHs = 0;
    int                   popsObs = 0;
    int                   checks = 0;
    int                   passes = 0;

    assign fifo_empty  = (rptr == wptr);
    assign fifo_dout   = mem[rptr[4:0]];
    assign fifo_r_ptr  = rptr;
    assign fifo_r_fail = failInject | (fifo_r_en & (fifo_empty | fifo_change_r_ptr_en));

    always #5 clk = ~clk;

    fifo_rd_port #(
        .WIDTH     (WIDTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .fifo_empty              (fifo_empty),
        .fifo_dout               (fifo_dout),
        .fifo_r_ptr              (fifo_r_ptr),
        .fifo_r_fail             (fifo_r_fail),
        .fifo_r_en               (fifo_r_en),
        .fifo_change_r_ptr_en    (fifo_change_r_ptr_en),
        .fifo_change_r_ptr_value (fifo_change_r_ptr_value),
        .out_valid               (out_valid),
        .out_data                (out_data),
        .out_ptr                 (out_ptr),
        .out_ready               (out_ready),
        .flush                   (flush),
        .flush_ptr               (flush_ptr),
        .err                     (err)
`ifdef FIFO_RD_PORT_STATS_EN
        ,
        .pop_cnt                 (pop_cnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_data"}, out_data, 32'd0);
        checkOutput({tag, "_ptr"}, 32'(out_ptr), 32'd0);
        checkOutput({tag, "_rd_en"}, 32'(fifo_r_en), 32'd0);
        checkOutput({tag, "_chg_en"}, 32'(fifo_change_r_ptr_en), 32'd0);
        checkOutput({tag, "_chg_val"}, 32'(fifo_change_r_ptr_value), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
`ifdef FIFO_RD_PORT_STATS_EN
        checkOutput({tag, "_pop_cnt"}, 32'(pop_cnt), 32'd0);
`endif
    endtask

    task automatic pushEntries(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wptr[4:0]] = $urandom;
            wptr = wptr + 6'd1;
        end
    endtask

    task automatic resetModel();
        nextPtr      = rptr;
        lastFlushPtr = '0;
        flushWindow  = 1'b0;
        errExp       = 1'b0;
        delivered    = 0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic applyStimulus(input logic fl, input logic [5:0] flp, input logic rdy,
                                 input logic wr, input logic failInj);
        logic [5:0] occ;
        logic       expValid;
        logic       expRdEn;
        logic       hs;
        logic       sampRdEn;
        logic       sampChg;
        logic [5:0] sampVal;
        flush      = fl;
        flush_ptr  = flp;
        out_ready  = rdy;
        failInject = failInj;
        #1;
        hs = 1'b0;
        if (flushWindow) begin
            checkOutput("chg_en_flush", 32'(fifo_change_r_ptr_en), 32'd1);
            checkOutput("chg_val_flush", 32'(fifo_change_r_ptr_value), 32'(lastFlushPtr));
            checkOutput("rd_en_flush", 32'(fifo_r_en), 32'd0);
            checkOutput("valid_flush", 32'(out_valid), 32'd0);
        end else begin
            occ      = rptr - nextPtr;
            expValid = (occ != 6'd0);
            expRdEn  = (rptr != wptr) && !fl && (occ < 6'd2);
            checkOutput("chg_en", 32'(fifo_change_r_ptr_en), 32'd0);
            checkOutput("valid", 32'(out_valid), 32'(expValid));
            checkOutput("rd_en", 32'(fifo_r_en), 32'(expRdEn));
            if (expValid) begin
                checkOutput("out_ptr", 32'(out_ptr), 32'(nextPtr));
                checkOutput("out_data", out_data, mem[nextPtr[4:0]]);
            end
            hs = expValid && rdy && !fl;
        end
        checkOutput("err", 32'(err), 32'(errExp));
`ifdef FIFO_RD_PORT_STATS_EN
        checkOutput("pop_cnt", 32'(pop_cnt), 32'(delivered % 65536));
`endif
        if (out_valid && rdy && !fl && !flushWindow) obsHs++;
        sampRdEn = fifo_r_en;
        sampChg  = fifo_change_r_ptr_en;
        sampVal  = fifo_change_r_ptr_value;
        @(posedge clk);
        #1;
        if (sampChg) rptr = sampVal;
        else if (sampRdEn) begin
            rptr = rptr + 6'd1;
            popsObs++;
        end
        if (wr && ((wptr - rptr) < 6'd20)) pushEntries(1);
        if (fl) begin
            nextPtr      = flp;
            lastFlushPtr = flp;
        end else if (hs) begin
            nextPtr = nextPtr + 6'd1;
            delivered++;
        end
        flushWindow = fl;
        if (failInj) errExp = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        pushEntries(8);
        #3;
        checkResetOutputs("reset");
        @(negedge clk);
        reset = 1'b0;
        resetModel();

        $display("[TB] stream of 8 entries");
        base = obsHs;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("stream_count", 32'(obsHs - base), 32'd8);

        $display("[TB] backpressure");
        pushEntries(4);
        base = popsObs;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_pops", 32'(popsObs - base), 32'd2);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

        $display("[TB] flush to pointer 3 with full buffer");
        pushEntries(4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

        $display("[TB] back-to-back flush");
        applyStimulus(1'b1, 6'd5, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset during flush");
        pushEntries(4);
        applyStimulus(1'b1, 6'd2, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs("midflush");
        flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rd_en_in_reset", 32'(fifo_r_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        resetModel();
        base = obsHs;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_count", 32'(obsHs - base), 32'd4);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic       fl;
            logic [5:0] flp;
            logic       rdy;
            logic       wr;
            fl  = ($urandom_range(0, 15) == 0);
            flp = nextPtr - 6'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 3) != 0);
            wr  = ($urandom_range(0, 1) != 0);
            applyStimulus(fl, flp, rdy, wr, 1'b0);
        end

`ifdef FIFO_RD_PORT_STATS_EN
        $display("[TB] pop counter wrap");
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        resetModel();
        for (int i = 0; i < 66000 && delivered < 65537; i++) begin
            applyStimulus(1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
        end
        #1;
        checkOutput("pop_cnt_wrap", 32'(pop_cnt), 32'd1);
        @(negedge clk);
`endif

        $display("[TB] illegal-read flag");
        applyStimulus(1'b0, 6'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("err_sticky", 32'(err), 32'd1);

        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
